// File: rtl/instruction_memory_sync_if.sv
// Fetch and load bus for the instruction memory.
// Handshakes: a request transfers on a rising edge where req_valid && req_ready,
// and a response transfers on a rising edge where rsp_valid && rsp_ready. The
// sender holds valid and its payload steady until the transfer happens.
interface instruction_memory_sync_if #(
  parameter int BYTE_W = 4,
  parameter int ADDR_W = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [8*BYTE_W-1:0]   rsp_data;
  logic [1:0]            rsp_err;
  logic                  ld_en;
  logic [ADDR_W-1:0]     ld_addr;
  logic [7:0]            ld_byte;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_byte,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_byte,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/instruction_memory_sync.sv
// Byte-addressed instruction memory with a wait-state fetch port returning
// little-endian words, error flags for misaligned / out-of-range fetches, and
// a byte-wide load port usable in any state.
module instruction_memory_sync #(
  parameter int BYTE_W   = 4,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  instruction_memory_sync_if.slave     bus,
  output logic [1:0]                   dbg_state_o
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]        LAST_WAIT = 4'(WAIT_CYC - 1);
  localparam logic [ADDR_W-1:0] BYTE_W_L  = ADDR_W'(BYTE_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [8*BYTE_W-1:0]   data_q, data_d;
  logic [1:0]            err_q, err_d;
  logic [7:0]            mem_q [DEPTH];

  logic [ADDR_W-1:0]     fetch_addr;
  logic [ADDR_W:0]       last_byte;
  logic                  oor;
  logic                  mis;
  logic [8*BYTE_W-1:0]   fetch_word;
  logic                  capture;

  // Assemble the word for the fetch being captured; reads old memory contents
  // so a same-edge load is not visible (read-before-write).
  always_comb begin
    fetch_addr = (state_q == S_IDLE) ? bus.req_addr : addr_q;
    last_byte  = {1'b0, fetch_addr} + (ADDR_W+1)'(BYTE_W - 1);
    oor        = (last_byte >= DEPTH_L);
    mis        = ((fetch_addr % BYTE_W_L) != '0);
    fetch_word = '0;
    if (!oor) begin
      for (int i = 0; i < BYTE_W; i++) begin
        fetch_word[8*i +: 8] = mem_q[IDX_W'({1'b0, fetch_addr} + (ADDR_W+1)'(i))];
      end
    end
  end

  // Next-state and datapath update for the IDLE / WAIT / RESP sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          cnt_d  = '0;
          if (WAIT_CYC == 0) begin
            state_d = S_RESP;
            capture = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_WAIT) begin
          state_d = S_RESP;
          capture = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      data_d = fetch_word;
      err_d  = {oor, mis};
    end
  end

  // State register; reset aborts any pending fetch but leaves memory alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Byte load port; writes beyond DEPTH are dropped.
  always_ff @(posedge clk) begin
    if (bus.ld_en && ({1'b0, bus.ld_addr} < DEPTH_L)) begin
      mem_q[IDX_W'(bus.ld_addr)] <= bus.ld_byte;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_data  = data_q;
    bus.rsp_err   = err_q;
    dbg_state_o   = state_q;
  end

endmodule
